uart_tx_frame: RTL and testbench

- UART transmitter; the transmit-direction counterpart of the UART RX path.
- Serializes one DATA_WIDTH word per request: start bit, data bits LSB first, optional parity bit, stop bit.
- Each bit lasts PRESCALE clk cycles; PRESCALE matches the RX oversample ratio so TX and RX share one clock.
- Sits between the host-side write interface and the serial line pin.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_tx_frame_if.sv | 32 +++
 rtl/uart_tx_bit_timer.sv | 31 +++
 rtl/uart_tx_frame.sv | 132 +++++++++++++
 tb/tb_uart_tx_frame.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit and receive paths.
//   tx_state_t  - transmitter FSM states.
//   PAR_EVEN/PAR_ODD - parity-type encodings for par_typ.
//   parity_bit() - parity of a word for a given parity type; words narrower
//                  than PAR_MAX_W are zero-extended by the caller, which does
//                  not change the XOR.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PAR_MAX_W = 64;

    // Even parity: bit makes the total count of ones even (= XOR of data).
    // Odd parity: inverse of that.
    function automatic logic parity_bit(input logic [PAR_MAX_W-1:0] word,
                                        input logic                 typ);
        return (^word) ^ (typ == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: host-side write interface of the UART transmitter.
//   data_in    - word to transmit (host -> tx)
//   data_valid - transmit request (host -> tx)
//   par_en     - append parity bit (host -> tx)
//   par_typ    - 0 = even, 1 = odd (host -> tx)
//   busy       - frame in progress (tx -> host)
//   done       - one-cycle pulse at frame completion (tx -> host)
//
// Handshake: a request is accepted on any rising clk edge where data_valid=1
// and busy=0; busy is the inverse of ready. data_in/par_en/par_typ are
// captured on that edge and may change freely afterwards. A request seen
// while busy=1 is dropped, never queued.
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic                  busy;
    logic                  done;

    modport master (
        output data_in, data_valid, par_en, par_typ,
        input  busy, done
    );

    modport slave (
        input  data_in, data_valid, par_en, par_typ,
        output busy, done
    );
endinterface

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: bit-period prescaler for the UART transmitter.
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - force the count to 0 (held while the line is idle)
//   run       - count while a frame is in progress
//   bit_tick  - high during the last cycle (count = PRESCALE-1) of a bit
module uart_tx_bit_timer #(
    parameter int PRESCALE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic bit_tick
);
    localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] count;

    assign bit_tick = run && !clear && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || bit_tick) begin
            count <= '0;
        end else if (run) begin
            count <= count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter. Sends start bit, DATA_WIDTH data bits
// LSB first, optional parity bit and stop bit(s); every bit lasts PRESCALE
// clk cycles.
//   clk, rst  - clock, asynchronous active-high reset
//   bus       - host write interface (slave side), see uart_tx_frame_if
//   tx_out    - registered serial line, idles high
//   fsm_state - current FSM state, for observation
// Build option: define UART_TX_STOP2_EN for two stop bits (STOP lasts
// 2*PRESCALE cycles); left undefined a single stop bit is sent.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_frame_if.slave    bus,
    output logic              tx_out,
    output tx_state_t         fsm_state
);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    tx_state_t             state;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  bit_tick;

    assign fsm_state  = state;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign shift_next = shift >> 1;

    uart_tx_bit_timer #(.PRESCALE(PRESCALE)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == IDLE),
        .run      (state != IDLE),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            shift     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tx_out    <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // busy is always low here, so data_valid alone accepts.
                    if (bus.data_valid) begin
                        shift     <= bus.data_in;
                        par_en_q  <= bus.par_en;
                        // Parity is resolved now so par_typ need not be kept.
                        par_bit_q <= parity_bit(PAR_MAX_W'(bus.data_in), bus.par_typ);
                        state     <= START;
                        busy_q    <= 1'b1;
                        tx_out    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state  <= DATA;
                        idx    <= '0;
                        tx_out <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (idx == LAST_IDX) begin
                            idx <= '0;
                            if (par_en_q) begin
                                state  <= PARITY;
                                tx_out <= par_bit_q;
                            end else begin
                                state  <= STOP;
                                tx_out <= 1'b1;
                            end
                        end else begin
                            idx    <= idx + IDX_W'(1);
                            shift  <= shift_next;
                            tx_out <= shift_next[0];
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        state  <= STOP;
                        idx    <= '0;
                        tx_out <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
`ifdef UART_TX_STOP2_EN
                        // idx counts the stop bits already sent.
                        if (idx == '0) begin
                            idx <= IDX_W'(1);
                        end else begin
                            state  <= IDLE;
                            idx    <= '0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
`else
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    tx_out <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed self-checking bench for uart_tx_frame.
// Honours UART_TX_STOP2_EN when defined for the build.
module tb_uart_tx_frame;
    import uart_pkg::*;

    localparam int DW = 8;
    localparam int PS = 8;
`ifdef UART_TX_STOP2_EN
    localparam int STOP_CYC = 2 * PS;
`else
    localparam int STOP_CYC = PS;
`endif

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      tx_out;
    tx_state_t fsm_state;

    uart_tx_frame_if #(.DATA_WIDTH(DW)) bus();

    uart_tx_frame #(.DATA_WIDTH(DW), .PRESCALE(PS)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .tx_out    (tx_out),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic tx_s[$];
    logic busy_s[$];
    logic done_s[$];
    logic exp_q[$];

    function automatic int frame_len(input logic pe);
        return PS * (1 + DW + (pe ? 1 : 0)) + STOP_CYC;
    endfunction

    function automatic int count_hi(input logic q[$]);
        int c = 0;
        foreach (q[i]) if (q[i] === 1'b1) c++;
        return c;
    endfunction

    // Expected per-cycle line levels of one frame, appended to exp_q.
    task automatic build_exp(input logic [DW-1:0] d, input logic pe, input logic pt);
        int   ones = 0;
        logic p;
        repeat (PS) exp_q.push_back(1'b0);
        for (int b = 0; b < DW; b++) begin
            repeat (PS) exp_q.push_back(d[b]);
            if (d[b]) ones++;
        end
        p = ((ones % 2) == 1) ^ pt;
        if (pe) repeat (PS) exp_q.push_back(p);
        repeat (STOP_CYC) exp_q.push_back(1'b1);
    endtask

    // Request one frame; returns at the negedge just after the acceptance edge
    // with the request inputs scrambled to prove they were latched.
    task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt);
        @(negedge clk);
        bus.data_in    = d;
        bus.par_en     = pe;
        bus.par_typ    = pt;
        bus.data_valid = 1'b1;
        @(negedge clk);
        bus.data_valid = 1'b0;
        bus.data_in    = ~d;
        bus.par_en     = ~pe;
        bus.par_typ    = ~pt;
    endtask

    // Sample n cycles at negedges; optionally raise/drop data_valid at given samples.
    task automatic capture(input int n, input int on_at, input int off_at,
                           input logic [DW-1:0] on_data);
        tx_s.delete(); busy_s.delete(); done_s.delete();
        for (int i = 0; i < n; i++) begin
            tx_s.push_back(tx_out);
            busy_s.push_back(bus.busy);
            done_s.push_back(bus.done);
            if (i == on_at) begin
                bus.data_valid = 1'b1;
                bus.data_in    = on_data;
            end
            if (i == off_at) bus.data_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (tx_out !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx_out); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_checks++; if (fsm_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", fsm_state, IDLE); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (tx_out !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: tx %b busy %b want 1 0", tx_out, bus.busy); end
    endtask

    task automatic test_parity_a5_even();
        int l = frame_len(1'b1);
        send(8'hA5, 1'b1, PAR_EVEN);
        capture(l + 6, -1, -1, '0);
        exp_q.delete();
        build_exp(8'hA5, 1'b1, 1'b0);
        repeat (6) exp_q.push_back(1'b1);
        foreach (exp_q[i]) begin
            n_checks++; if (tx_s[i] !== exp_q[i]) begin n_fail++; $display("FAIL a5_line[%0d]: got %b want %b", i, tx_s[i], exp_q[i]); end
        end
        n_checks++; if (count_hi(busy_s) != l) begin n_fail++; $display("FAIL a5_busy_len: got %0d want %0d", count_hi(busy_s), l); end
        n_checks++; if (count_hi(done_s) != 1 || done_s[l] !== 1'b1) begin n_fail++; $display("FAIL a5_done: count %0d at_end %b want 1 1", count_hi(done_s), done_s[l]); end
        n_checks++; if (tx_s[PS*9 + PS/2] !== 1'b0) begin n_fail++; $display("FAIL a5_parity: got %b want 0", tx_s[PS*9 + PS/2]); end
    endtask

    task automatic test_parity_01();
        for (int t = 0; t < 2; t++) begin
            logic pt  = (t == 1) ? PAR_ODD : PAR_EVEN;
            logic want = (t == 1) ? 1'b0 : 1'b1;
            send(8'h01, 1'b1, pt);
            capture(frame_len(1'b1) + 2, -1, -1, '0);
            exp_q.delete();
            build_exp(8'h01, 1'b1, pt);
            n_checks++; if (tx_s[PS*9 + PS/2] !== want) begin n_fail++; $display("FAIL p01_parity typ%0d: got %b want %b", t, tx_s[PS*9 + PS/2], want); end
            foreach (exp_q[i]) begin
                n_checks++; if (tx_s[i] !== exp_q[i]) begin n_fail++; $display("FAIL p01_line typ%0d [%0d]: got %b want %b", t, i, tx_s[i], exp_q[i]); end
            end
            n_checks++; if (count_hi(done_s) != 1) begin n_fail++; $display("FAIL p01_done typ%0d: got %0d want 1", t, count_hi(done_s)); end
        end
    endtask

    task automatic test_no_parity_ff();
        int l = frame_len(1'b0);
        send(8'hFF, 1'b0, PAR_EVEN);
        capture(l + 4, -1, -1, '0);
        exp_q.delete();
        build_exp(8'hFF, 1'b0, 1'b0);
        foreach (exp_q[i]) begin
            n_checks++; if (tx_s[i] !== exp_q[i]) begin n_fail++; $display("FAIL ff_line[%0d]: got %b want %b", i, tx_s[i], exp_q[i]); end
        end
        n_checks++; if (count_hi(busy_s) != l) begin n_fail++; $display("FAIL ff_busy_len: got %0d want %0d", count_hi(busy_s), l); end
        n_checks++; if (busy_s[l-1] !== 1'b1 || busy_s[l] !== 1'b0 || done_s[l] !== 1'b1) begin n_fail++; $display("FAIL ff_end: busy %b%b done %b want 10 1", busy_s[l-1], busy_s[l], done_s[l]); end
    endtask

    task automatic test_ignored_request();
        int l = frame_len(1'b1);
        send(8'hA5, 1'b1, PAR_EVEN);
        capture(l + 20, 19, 20, 8'h00);
        exp_q.delete();
        build_exp(8'hA5, 1'b1, 1'b0);
        repeat (20) exp_q.push_back(1'b1);
        foreach (exp_q[i]) begin
            n_checks++; if (tx_s[i] !== exp_q[i]) begin n_fail++; $display("FAIL ign_line[%0d]: got %b want %b", i, tx_s[i], exp_q[i]); end
        end
        n_checks++; if (count_hi(busy_s) != l) begin n_fail++; $display("FAIL ign_busy_len: got %0d want %0d", count_hi(busy_s), l); end
        n_checks++; if (count_hi(done_s) != 1) begin n_fail++; $display("FAIL ign_done: got %0d want 1", count_hi(done_s)); end
        n_checks++; if (fsm_state !== IDLE) begin n_fail++; $display("FAIL ign_state: got %0d want %0d", fsm_state, IDLE); end
    endtask

    task automatic test_reset_mid_frame();
        int l = frame_len(1'b0);
        send(8'hA5, 1'b1, PAR_EVEN);
        repeat (29) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (tx_out !== 1'b1) begin n_fail++; $display("FAIL midrst_tx: got %b want 1", tx_out); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0 || fsm_state !== IDLE) begin n_fail++; $display("FAIL midrst_state: done %b state %0d want 0 %0d", bus.done, fsm_state, IDLE); end
        @(negedge clk);
        rst = 1'b0;
        send(8'h5A, 1'b0, PAR_ODD);
        capture(l + 2, -1, -1, '0);
        exp_q.delete();
        build_exp(8'h5A, 1'b0, 1'b1);
        foreach (exp_q[i]) begin
            n_checks++; if (tx_s[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_line[%0d]: got %b want %b", i, tx_s[i], exp_q[i]); end
        end
        n_checks++; if (count_hi(busy_s) != l) begin n_fail++; $display("FAIL midrst_busy_len: got %0d want %0d", count_hi(busy_s), l); end
    endtask

    task automatic test_back_to_back();
        int f = frame_len(1'b0);
        @(negedge clk);
        bus.data_in    = 8'h3C;
        bus.par_en     = 1'b0;
        bus.par_typ    = PAR_EVEN;
        bus.data_valid = 1'b1;
        @(negedge clk);
        bus.data_in    = 8'hC3;
        capture(2*f + 5, -1, f + 1, '0);
        exp_q.delete();
        build_exp(8'h3C, 1'b0, 1'b0);
        exp_q.push_back(1'b1);
        build_exp(8'hC3, 1'b0, 1'b0);
        repeat (4) exp_q.push_back(1'b1);
        foreach (exp_q[i]) begin
            n_checks++; if (tx_s[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_line[%0d]: got %b want %b", i, tx_s[i], exp_q[i]); end
        end
        n_checks++; if (tx_s[f] !== 1'b1 || tx_s[f+1] !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got %b%b want 10", tx_s[f], tx_s[f+1]); end
        n_checks++; if (count_hi(done_s) != 2 || done_s[f] !== 1'b1 || done_s[2*f+1] !== 1'b1) begin n_fail++; $display("FAIL b2b_done: count %0d want 2", count_hi(done_s)); end
        n_checks++; if (count_hi(busy_s) != 2*f) begin n_fail++; $display("FAIL b2b_busy_len: got %0d want %0d", count_hi(busy_s), 2*f); end
        n_checks++; if (tx_s[2*f-STOP_CYC] !== 1'b1 || tx_s[2*f-STOP_CYC] !== tx_s[2*f]) begin n_fail++; $display("FAIL b2b_stop: got %b want 1", tx_s[2*f-STOP_CYC]); end
    endtask

    initial begin
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        bus.par_en     = 1'b0;
        bus.par_typ    = 1'b0;
        test_reset();
        test_parity_a5_even();
        test_parity_01();
        test_no_parity_ff();
        test_ignored_request();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
